upper_imm_exec_pipe: RTL and testbench

- Parametrised, pipelined execute unit for RV32I/RV64I upper-immediate and direct-jump instructions: LUI, AUIPC and JAL.
- Sits in the ALU path between decode and writeback.
- Produces the register write value and, for JAL, a redirect target.
- Uses a valid/ready handshake on both sides, a configurable pipeline depth, a flush input, and a retired-instruction counter.

---
 rtl/upper_imm_exec_pipe.sv | 137 +++++++++++++
 tb/tb_upper_imm_exec_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upper_imm_exec_pipe.sv
`default_nettype none
// ============================================================================
// upper_imm_exec_pipe : pipelined LUI / AUIPC / JAL execute unit, valid/ready
// Rev 1.0
// ============================================================================
module upper_imm_exec_pipe #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 8,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iFLUSH,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic [31:0]      iIR,
  input  logic [PC_W-1:0]  iPC,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [4:0]       oRD,
  output logic [XLEN-1:0]  oREG_IN,
  output logic             oWE,
  output logic             oJUMP,
  output logic [PC_W-1:0]  oTARGET,
  output logic             oILLEGAL,
  output logic [CNT_W-1:0] oRETIRED
);

  localparam logic [6:0] C_OP_LUI   = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic            ill;
    logic [PC_W-1:0] tgt;
    logic            jump;
    logic            we;
    logic [XLEN-1:0] val;
    logic [4:0]      rd;
  } pay_t;

  logic [XLEN-1:0]  w_uimm;
  logic [XLEN-1:0]  w_pcx;
  logic [20:0]      w_jimm;
  logic [PC_W-1:0]  w_jtgt;
  logic             w_rd_nz;
  pay_t             w_dec;

  pay_t             r_pay [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNT_W-1:0] r_ret;

  logic [DEPTH-1:0] w_adv;
  logic             w_load0;
  logic             w_fire;

  assign w_uimm  = XLEN'($signed({iIR[31:12], 12'h000}));
  assign w_pcx   = XLEN'(iPC);
  assign w_jimm  = {iIR[31], iIR[19:12], iIR[20], iIR[30:21], 1'b0};
  assign w_jtgt  = iPC + PC_W'($signed(w_jimm));
  assign w_rd_nz = (iIR[11:7] != 5'd0);

  always_comb begin
    w_dec    = '0;
    w_dec.rd = iIR[11:7];
    case (iIR[6:0])
      C_OP_LUI: begin
        w_dec.val = w_uimm;
        w_dec.we  = w_rd_nz;
      end
      C_OP_AUIPC: begin
        w_dec.val = w_pcx + w_uimm;
        w_dec.we  = w_rd_nz;
      end
      C_OP_JAL: begin
        w_dec.val  = w_pcx + XLEN'(4);
        w_dec.we   = w_rd_nz;
        w_dec.jump = 1'b1;
        w_dec.tgt  = w_jtgt;
      end
      default: w_dec.ill = 1'b1;
    endcase
  end

  // Walk from the output back to stage 0: a stage advances when the one
  // above it is empty or advancing, so bubbles collapse during a stall.
  always_comb begin : p_advance
    logic v_room;
    w_adv  = '0;
    v_room = iREADY & ~iFLUSH;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_adv[k] = r_vld[k] & v_room;
      v_room   = ~r_vld[k] | w_adv[k];
    end
    w_load0 = v_room;
  end

  assign w_fire = r_vld[DEPTH-1] & ~iFLUSH & iREADY;
  assign oREADY = iFLUSH | w_load0;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vld <= '0;
      for (int k = 0; k < DEPTH; k++) r_pay[k] <= '0;
    end else if (iFLUSH) begin
      r_vld <= '0;
    end else begin
      if (w_load0) begin
        r_vld[0] <= iVALID;
        if (iVALID) r_pay[0] <= w_dec;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (~r_vld[k] | w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) r_pay[k] <= r_pay[k-1];
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)     r_ret <= '0;
    else if (w_fire) r_ret <= r_ret + CNT_W'(1);
  end

  assign oVALID   = r_vld[DEPTH-1] & ~iFLUSH;
  assign oRD      = r_pay[DEPTH-1].rd;
  assign oREG_IN  = r_pay[DEPTH-1].val;
  assign oWE      = r_pay[DEPTH-1].we;
  assign oJUMP    = r_pay[DEPTH-1].jump;
  assign oTARGET  = r_pay[DEPTH-1].tgt;
  assign oILLEGAL = r_pay[DEPTH-1].ill;
  assign oRETIRED = r_ret;

endmodule
`default_nettype wire

// File: tb/tb_upper_imm_exec_pipe.sv
`default_nettype none
// ============================================================================
// tb_upper_imm_exec_pipe : self-checking bench, three parameter sets
// Rev 1.0
// ============================================================================
module tb_upper_imm_exec_pipe;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] val;
    logic        we;
    logic        jump;
    logic [15:0] tgt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    logic [7:0]  pc;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        we;
    logic        jump;
    logic [7:0]  tgt;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH=1, XLEN=32, PC_W=8
  logic a_flush, a_ivalid, a_oready, a_ovalid, a_iready, a_we, a_jump, a_ill;
  logic [31:0] a_ir, a_val;
  logic [7:0]  a_pc, a_tgt;
  logic [4:0]  a_rd;
  logic [15:0] a_ret;
  // DEPTH=3, XLEN=32, PC_W=8
  logic b_flush, b_ivalid, b_oready, b_ovalid, b_iready, b_we, b_jump, b_ill;
  logic [31:0] b_ir, b_val;
  logic [7:0]  b_pc, b_tgt;
  logic [4:0]  b_rd;
  logic [15:0] b_ret;
  // DEPTH=2, XLEN=64, PC_W=16, CNT_W=4
  logic c_flush, c_ivalid, c_oready, c_ovalid, c_iready, c_we, c_jump, c_ill;
  logic [31:0] c_ir;
  logic [63:0] c_val;
  logic [15:0] c_pc, c_tgt;
  logic [4:0]  c_rd;
  logic [3:0]  c_ret;

  upper_imm_exec_pipe #(.XLEN(32), .PC_W(8), .DEPTH(1), .CNT_W(16)) u_d1 (
    .iCLK(clk), .iRST_N(rst_n), .iFLUSH(a_flush), .iVALID(a_ivalid), .oREADY(a_oready),
    .iIR(a_ir), .iPC(a_pc), .oVALID(a_ovalid), .iREADY(a_iready), .oRD(a_rd),
    .oREG_IN(a_val), .oWE(a_we), .oJUMP(a_jump), .oTARGET(a_tgt), .oILLEGAL(a_ill),
    .oRETIRED(a_ret));

  upper_imm_exec_pipe #(.XLEN(32), .PC_W(8), .DEPTH(3), .CNT_W(16)) u_d3 (
    .iCLK(clk), .iRST_N(rst_n), .iFLUSH(b_flush), .iVALID(b_ivalid), .oREADY(b_oready),
    .iIR(b_ir), .iPC(b_pc), .oVALID(b_ovalid), .iREADY(b_iready), .oRD(b_rd),
    .oREG_IN(b_val), .oWE(b_we), .oJUMP(b_jump), .oTARGET(b_tgt), .oILLEGAL(b_ill),
    .oRETIRED(b_ret));

  upper_imm_exec_pipe #(.XLEN(64), .PC_W(16), .DEPTH(2), .CNT_W(4)) u_x64 (
    .iCLK(clk), .iRST_N(rst_n), .iFLUSH(c_flush), .iVALID(c_ivalid), .oREADY(c_oready),
    .iIR(c_ir), .iPC(c_pc), .oVALID(c_ovalid), .iREADY(c_iready), .oRD(c_rd),
    .oREG_IN(c_val), .oWE(c_we), .oJUMP(c_jump), .oTARGET(c_tgt), .oILLEGAL(c_ill),
    .oRETIRED(c_ret));

  // Reference: instruction semantics from plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] ir, input longint unsigned pc,
                                 input int xlen, input int pcw);
    exp_t e;
    longint unsigned upper, jimm, vmask, pmask;
    int s;
    e     = '0;
    e.rd  = ir[11:7];
    vmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    pmask = (64'd1 << pcw) - 64'd1;
    s     = int'(ir & 32'hFFFF_F000);
    upper = longint'(s);
    jimm  = 64'(ir[30:21]) * 2 + 64'(ir[20]) * 2048 + 64'(ir[19:12]) * 4096;
    if (ir[31]) jimm = jimm - (64'd1 << 20);
    case (ir[6:0])
      7'h37: begin e.val = upper;      e.we = (e.rd != 0); end
      7'h17: begin e.val = pc + upper; e.we = (e.rd != 0); end
      7'h6F: begin
        e.val  = pc + 64'd4;
        e.we   = (e.rd != 0);
        e.jump = 1'b1;
        e.tgt  = 16'((pc + jimm) & pmask);
      end
      default: e.ill = 1'b1;
    endcase
    e.val = e.val & vmask;
    return e;
  endfunction

  function automatic exp_t mk(input logic [4:0] rd, input logic [63:0] v, input logic we,
                              input logic jp, input logic [15:0] t, input logic il);
    exp_t e;
    e.rd = rd; e.val = v; e.we = we; e.jump = jp; e.tgt = t; e.ill = il;
    return e;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 5))
      0:       op = 7'h37;
      1:       op = 7'h17;
      2:       op = 7'h6F;
      3:       op = 7'h33;
      4:       op = 7'h03;
      default: op = 7'h7F;
    endcase
    return {r[31:7], op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkp(input string nm, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboards: accepted-but-not-retired instructions in order.
  exp_t q3[$];
  exp_t qx[$];
  int   b_cyc, lat_acc, lat_out, b_pushed, b_killed, c_pushed;
  logic b_acc, c_acc;

  task automatic d3_cycle();
    #1;
    b_acc = b_ivalid && b_oready && !b_flush;
    if (b_ovalid) begin
      if (lat_out < 0) lat_out = b_cyc;
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL d3_spurious: got oVALID=1 want 0");
      end else begin
        chkp("d3_payload", mk(b_rd, 64'(b_val), b_we, b_jump, 16'(b_tgt), b_ill), q3[0]);
        if (b_iready) void'(q3.pop_front());
      end
    end
    if (b_flush) begin
      b_killed += q3.size();
      q3.delete();
    end
    if (b_acc) begin
      q3.push_back(model(b_ir, 64'(b_pc), 32, 8));
      b_pushed++;
      if (lat_acc < 0) lat_acc = b_cyc;
    end
    b_cyc++;
    @(negedge clk);
  endtask

  task automatic x_cycle();
    #1;
    c_acc = c_ivalid && c_oready && !c_flush;
    if (c_ovalid) begin
      if (qx.size() == 0) begin
        total++; bad++;
        $display("FAIL x64_spurious: got oVALID=1 want 0");
      end else begin
        chkp("x64_payload", mk(c_rd, c_val, c_we, c_jump, c_tgt, c_ill), qx[0]);
        if (c_iready) void'(qx.pop_front());
      end
    end
    if (c_acc) begin
      qx.push_back(model(c_ir, 64'(c_pc), 64, 16));
      c_pushed++;
    end
    @(negedge clk);
  endtask

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h123452B7, 8'h00, 5'd5, 32'h12345000, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{32'h00001097, 8'h40, 5'd1, 32'h00001040, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{32'h008000EF, 8'h10, 5'd1, 32'h00000014, 1'b1, 1'b1, 8'h18, 1'b0};
    tbl[3] = '{32'hFF9FF06F, 8'h04, 5'd0, 32'h00000008, 1'b0, 1'b1, 8'hFC, 1'b0};
    tbl[4] = '{32'h00000033, 8'h20, 5'd0, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{32'hABCDE037, 8'h55, 5'd0, 32'hABCDE000, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{32'hFFFFF197, 8'h80, 5'd3, 32'hFFFFF080, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{32'h0200016F, 8'hF0, 5'd2, 32'h000000F4, 1'b1, 1'b1, 8'h10, 1'b0};

    rst_n = 1'b0;
    {a_flush, a_ivalid, b_flush, b_ivalid, c_flush, c_ivalid} = '0;
    {a_iready, b_iready, c_iready} = 3'b111;
    a_ir = '0; a_pc = '0; b_ir = '0; b_pc = '0; c_ir = '0; c_pc = '0;
    b_cyc = 0; lat_acc = -1; lat_out = -1; b_pushed = 0; b_killed = 0; c_pushed = 0;
    b_acc = 1'b0; c_acc = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_ovalid", 64'(a_ovalid), 64'd0);
    chk("rst_oready", 64'(a_oready), 64'd1);
    chk("rst_retired", 64'(a_ret), 64'd0);
    chkp("rst_payload", mk(a_rd, 64'(a_val), a_we, a_jump, 16'(a_tgt), a_ill), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // DEPTH=1 directed vectors
    for (int i = 0; i < 8; i++) begin
      a_ivalid = 1'b1; a_ir = tbl[i].ir; a_pc = tbl[i].pc;
      @(negedge clk);
      a_ivalid = 1'b0;
      #1;
      chk($sformatf("d1_vec%0d_valid", i), 64'(a_ovalid), 64'd1);
      chkp($sformatf("d1_vec%0d_payload", i),
           mk(a_rd, 64'(a_val), a_we, a_jump, 16'(a_tgt), a_ill),
           mk(tbl[i].rd, 64'(tbl[i].val), tbl[i].we, tbl[i].jump, 16'(tbl[i].tgt), tbl[i].ill));
      @(negedge clk);
    end
    #1;
    chk("d1_retired", 64'(a_ret), 64'd8);
    chk("d1_idle_ovalid", 64'(a_ovalid), 64'd0);
    @(negedge clk);

    // DEPTH=3: six back-to-back LUIs, downstream stalled for cycles 4..7
    begin
      int idx;
      idx = 0; b_cyc = 0; lat_acc = -1; lat_out = -1;
      for (int c = 0; c < 20; c++) begin
        b_ivalid = (idx < 6);
        b_ir     = (32'(idx + 1) << 12) | (32'(idx + 1) << 7) | 32'h37;
        b_pc     = 8'($urandom());
        b_iready = !(c >= 4 && c <= 7);
        d3_cycle();
        if (b_acc) idx++;
      end
      b_ivalid = 1'b0;
      chk("d3_latency", 64'(lat_out - lat_acc), 64'd3);
      chk("d3_stream_drained", 64'(q3.size()), 64'd0);
      chk("d3_retired6", 64'(b_ret), 64'd6);
    end

    // DEPTH=3: fill, flush with a valid input, then refill
    b_iready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      b_ivalid = 1'b1; b_ir = {20'($urandom()), 5'd7, 7'h37}; b_pc = 8'($urandom());
      d3_cycle();
    end
    #1;
    chk("d3_full_ovalid", 64'(b_ovalid), 64'd1);
    chk("d3_full_oready", 64'(b_oready), 64'd0);
    b_flush = 1'b1; b_ivalid = 1'b1; b_iready = 1'b1; b_ir = 32'h0AAAA137;
    #1;
    chk("flush_ovalid", 64'(b_ovalid), 64'd0);
    chk("flush_oready", 64'(b_oready), 64'd1);
    d3_cycle();
    b_flush = 1'b0; b_ivalid = 1'b1; b_ir = 32'h5555_5237; b_pc = 8'h33;
    #1;
    chk("post_flush_empty", 64'(b_ovalid), 64'd0);
    chk("post_flush_ready", 64'(b_oready), 64'd1);
    b_cyc = 0; lat_acc = -1; lat_out = -1;
    d3_cycle();
    b_ivalid = 1'b0;
    for (int c = 0; c < 6; c++) d3_cycle();
    chk("flush_refill_latency", 64'(lat_out - lat_acc), 64'd3);
    chk("flush_retired", 64'(b_ret), 64'd7);

    // DEPTH=3: randomized traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      b_ivalid = ($urandom_range(0, 3) != 0);
      b_ir     = rand_ir();
      b_pc     = 8'($urandom());
      b_iready = ($urandom_range(0, 3) != 0);
      b_flush  = ($urandom_range(0, 39) == 0);
      d3_cycle();
    end
    b_ivalid = 1'b0; b_flush = 1'b0; b_iready = 1'b1;
    for (int c = 0; c < 8; c++) d3_cycle();
    chk("d3_rand_drained", 64'(q3.size()), 64'd0);
    chk("d3_rand_retired", 64'(b_ret), 64'(16'(b_pushed - b_killed)));

    // XLEN=64: sign extension of LUI, then 16 more transfers to wrap a 4-bit counter
    c_ivalid = 1'b1; c_ir = 32'h800002B7; c_pc = 16'h1234; c_iready = 1'b0;
    x_cycle();
    c_ivalid = 1'b0;
    x_cycle();
    #1;
    chk("x64_lui_valid", 64'(c_ovalid), 64'd1);
    chk("x64_lui_val", c_val, 64'hFFFF_FFFF_8000_0000);
    chk("x64_lui_we", 64'(c_we), 64'd1);
    c_iready = 1'b1;
    x_cycle();
    begin
      int n;
      n = 0;
      for (int c = 0; c < 200 && n < 16; c++) begin
        c_ivalid = 1'b1; c_ir = rand_ir(); c_pc = 16'($urandom());
        c_iready = 1'($urandom_range(0, 1));
        x_cycle();
        if (c_acc) n++;
      end
      chk("x64_accept_budget", 64'(n), 64'd16);
    end
    c_ivalid = 1'b0; c_iready = 1'b1;
    for (int c = 0; c < 6; c++) x_cycle();
    chk("x64_drained", 64'(qx.size()), 64'd0);
    chk("x64_retired_wrap", 64'(c_ret), 64'd1);

    // DEPTH=3: asynchronous reset with two instructions in flight
    b_iready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      b_ivalid = 1'b1; b_ir = {20'($urandom()), 5'd9, 7'h6F}; b_pc = 8'($urandom());
      d3_cycle();
    end
    b_ivalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 64'(b_ovalid), 64'd0);
    chk("arst_oready", 64'(b_oready), 64'd1);
    chk("arst_retired", 64'(b_ret), 64'd0);
    chkp("arst_payload", mk(b_rd, 64'(b_val), b_we, b_jump, 16'(b_tgt), b_ill), '0);
    @(negedge clk);
    rst_n = 1'b1;
    q3.delete(); b_pushed = 0; b_killed = 0;
    b_iready = 1'b1;
    for (int c = 0; c < 5; c++) d3_cycle();
    chk("arst_no_resurrect", 64'(b_ret), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
